// File: rtl/rapids_mem_arbiter_if.sv
// Fetch, data and memory-side bus bundle for rapids_mem_arbiter.
// slave = arbiter side, master = requesters plus memory array.
interface rapids_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/rapids_mem_arbiter.sv
// Single-port main memory arbiter: data-priority with fetch starvation guard.
// Define ARB_STATS_EN to enable the saturating per-port grant counters.
module rapids_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    rapids_mem_arbiter_if.slave bus,
    output logic        busy,
    output logic [15:0] if_gnt_cnt,
    output logic [15:0] d_gnt_cnt
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int SCW = $clog2(MAX_WAIT + 1);
    localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(MEM_LAT - 1);

    logic [1:0]     state;
    logic [SCW-1:0] starve_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           owner_d;
    logic           is_store;
    logic           decide;
    logic           pick_if;

    always_comb begin
        decide  = (state == IDLE) && !hold && (bus.if_req || bus.d_req);
        pick_if = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            wait_cnt      <= '0;
            owner_d       <= 1'b0;
            is_store      <= 1'b0;
            busy          <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (decide) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        bus.mem_en <= 1'b1;
                        if (pick_if) begin
                            owner_d       <= 1'b0;
                            is_store      <= 1'b0;
                            bus.if_gnt    <= 1'b1;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_be    <= 4'hF;
                            starve_cnt    <= '0;
                        end else begin
                            owner_d       <= 1'b1;
                            is_store      <= bus.d_we;
                            bus.d_gnt     <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_be    <= bus.d_be;
                            if (bus.if_req && (starve_cnt != STARVE_MAX))
                                starve_cnt <= starve_cnt + SCW'(1);
                        end
                    end
                end
                ACCESS: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    // Capture lands directly in the owner's output register,
                    // so RESP needs no separate data latch.
                    if (wait_cnt == '0) begin
                        state <= RESP;
                        if (owner_d) begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_rdata  <= is_store ? '0 : bus.mem_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if_gnt_cnt <= '0;
            d_gnt_cnt  <= '0;
        end else if (decide) begin
            if (pick_if) begin
                if (if_gnt_cnt != 16'hFFFF) if_gnt_cnt <= if_gnt_cnt + 16'd1;
            end else begin
                if (d_gnt_cnt != 16'hFFFF) d_gnt_cnt <= d_gnt_cnt + 16'd1;
            end
        end
    end
`else
    assign if_gnt_cnt = '0;
    assign d_gnt_cnt  = '0;
`endif

endmodule

// File: tb/tb_rapids_mem_arbiter.sv
// Directed self-checking bench for rapids_mem_arbiter (MEM_LAT=1, MAX_WAIT=4).
module tb_rapids_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold;
    logic        busy;
    logic [15:0] if_gnt_cnt;
    logic [15:0] d_gnt_cnt;
    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;

    rapids_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    rapids_mem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .bus(bus),
        .busy(busy), .if_gnt_cnt(if_gnt_cnt), .d_gnt_cnt(d_gnt_cnt)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous memory with byte-enabled writes.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin step(); n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_timeout busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        step(); step();
        tests++;
        if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
             bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got nonzero gnt=%b%b rv=%b%b en=%b busy=%b want all 0",
                     bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, busy);
        end
        tests++;
        if ({if_gnt_cnt, d_gnt_cnt} !== 32'd0) begin
            fails++; $display("FAIL reset_stats got %h/%h want 0/0", if_gnt_cnt, d_gnt_cnt);
        end
        reset_n = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_load();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd64;
        step();  // cycle 1
        tests++;
        if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, busy} !== 5'b10101) begin
            fails++; $display("FAIL load_c1 gnt/ign/en/we/busy=%b want 10101",
                              {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, busy});
        end
        tests++;
        if (bus.mem_addr !== 16'd64) begin fails++; $display("FAIL load_addr got %0d want 64", bus.mem_addr); end
        bus.d_req = 1'b0;
        step();  // cycle 2
        tests++;
        if ({bus.d_gnt, bus.mem_en, bus.d_rvalid, busy} !== 4'b0001) begin
            fails++; $display("FAIL load_c2 gnt/en/rv/busy=%b want 0001",
                              {bus.d_gnt, bus.mem_en, bus.d_rvalid, busy});
        end
        step();  // cycle 3
        tests++;
        if ({bus.d_rvalid, bus.if_rvalid, busy} !== 3'b101) begin
            fails++; $display("FAIL load_c3 rv/irv/busy=%b want 101", {bus.d_rvalid, bus.if_rvalid, busy});
        end
        tests++;
        if (bus.d_rdata !== 32'd10) begin fails++; $display("FAIL load_data got %0d want 10", bus.d_rdata); end
        step();  // cycle 4
        tests++;
        if ({bus.d_rvalid, busy} !== 2'b00) begin
            fails++; $display("FAIL load_c4 rv/busy=%b want 00", {bus.d_rvalid, busy});
        end
    endtask

    task automatic test_store_fetch();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd5;
        bus.d_wdata = 32'h9EF10004; bus.d_be = 4'hF;
        step();  // cycle 1
        tests++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin
            fails++; $display("FAIL store_c1 gnt/en/we=%b want 111", {bus.d_gnt, bus.mem_en, bus.mem_we});
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();  // cycle 2
        tests++;
        if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL store_we_c2 got %b want 0", bus.mem_we); end
        step();  // cycle 3
        tests++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'd0}) begin
            fails++; $display("FAIL store_ack rv=%b data=%h want 1/00000000", bus.d_rvalid, bus.d_rdata);
        end
        bus.if_req = 1'b1; bus.if_addr = 16'd5;
        step();  // cycle 4, IDLE
        tests++;
        if (bus.if_gnt !== 1'b0) begin fails++; $display("FAIL fetch_early got %b want 0", bus.if_gnt); end
        step();  // cycle 5
        tests++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_we, bus.mem_be} !== {3'b100, 4'hF}) begin
            fails++; $display("FAIL fetch_gnt gnt/dg/we/be=%b want 100_1111",
                              {bus.if_gnt, bus.d_gnt, bus.mem_we, bus.mem_be});
        end
        bus.if_req = 1'b0;
        step(); step();  // cycle 7
        tests++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata} !== {2'b10, 32'h9EF10004}) begin
            fails++; $display("FAIL fetch_data rv=%b drv=%b data=%h want 1/0/9ef10004",
                              bus.if_rvalid, bus.d_rvalid, bus.if_rdata);
        end
        step();
    endtask

    task automatic test_simultaneous();
        bus.if_req = 1'b1; bus.if_addr = 16'd7;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd8;
        step();  // cycle 1
        tests++;
        if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin
            fails++; $display("FAIL simul_first dg/ig=%b want 10", {bus.d_gnt, bus.if_gnt});
        end
        bus.d_req = 1'b0;
        step(); step();  // cycle 3
        tests++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h88}) begin
            fails++; $display("FAIL simul_dresp rv=%b data=%h want 1/88", bus.d_rvalid, bus.d_rdata);
        end
        step(); step();  // cycle 5
        tests++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
            fails++; $display("FAIL simul_second ig/dg=%b want 10", {bus.if_gnt, bus.d_gnt});
        end
        bus.if_req = 1'b0;
        step(); step();  // cycle 7
        tests++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h77}) begin
            fails++; $display("FAIL simul_iresp rv=%b data=%h want 1/77", bus.if_rvalid, bus.if_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] seq;
        int n = 0;
        int cyc = 0;
        int both = 0;
        seq = '0;
        bus.if_req = 1'b1; bus.if_addr = 16'd3;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd4;
        while (n < 10 && cyc < 80) begin
            step(); cyc++;
            if (bus.if_gnt && bus.d_gnt) both++;
            if (bus.if_gnt || bus.d_gnt) begin
                seq[n] = bus.if_gnt;
                n++;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tests++;
        if (n !== 10) begin fails++; $display("FAIL starve_count got %0d grants want 10", n); end
        tests++;
        if (seq !== 10'b1000010000) begin
            fails++; $display("FAIL starve_order got %b want 1000010000 (bit0 first, 1=fetch)", seq);
        end
        tests++;
        if (both !== 0) begin fails++; $display("FAIL starve_dual got %0d want 0", both); end
        wait_idle();
        step();
    endtask

    task automatic test_hold();
        int g = 0;
        int b = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd8;
        step();  // cycle 1
        bus.d_req = 1'b0;
        step();  // cycle 2, WAIT
        hold = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'd7;
        step();  // cycle 3
        tests++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h88}) begin
            fails++; $display("FAIL hold_resp rv=%b data=%h want 1/88", bus.d_rvalid, bus.d_rdata);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.if_gnt || bus.d_gnt) g++;
            if (busy) b++;
        end
        tests++;
        if ({g, b} !== {32'd0, 32'd0}) begin
            fails++; $display("FAIL hold_quiet grants=%0d busy_cycles=%0d want 0/0", g, b);
        end
        hold = 1'b0;
        step();
        tests++;
        if (bus.if_gnt !== 1'b1) begin fails++; $display("FAIL hold_release if_gnt=%b want 1", bus.if_gnt); end
        bus.if_req = 1'b0;
        wait_idle();
        step();
    endtask

    task automatic test_reset_wait();
        int rv = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd8;
        step();  // cycle 1
        bus.d_req = 1'b0;
`ifdef ARB_STATS_EN
        tests++;
        if ({if_gnt_cnt, d_gnt_cnt} !== {16'd5, 16'd13}) begin
            fails++; $display("FAIL stats_count got %0d/%0d want 5/13", if_gnt_cnt, d_gnt_cnt);
        end
`endif
        step();  // cycle 2, WAIT
        reset_n = 1'b1;
        step();
        tests++;
        if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
             bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, busy} !== '0) begin
            fails++;
            $display("FAIL rstwait_outputs rv=%b%b drdata=%h irdata=%h addr=%h busy=%b want all 0",
                     bus.if_rvalid, bus.d_rvalid, bus.d_rdata, bus.if_rdata, bus.mem_addr, busy);
        end
        tests++;
        if ({if_gnt_cnt, d_gnt_cnt} !== 32'd0) begin
            fails++; $display("FAIL rstwait_stats got %0d/%0d want 0/0", if_gnt_cnt, d_gnt_cnt);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.d_rvalid || bus.if_rvalid || busy) rv++;
        end
        tests++;
        if (rv !== 0) begin fails++; $display("FAIL rstwait_quiet got %0d active cycles want 0", rv); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) ^ 32'hA5A50000;
        mem[64] = 32'd10;
        mem[7]  = 32'h77;
        mem[8]  = 32'h88;
        reset_n = 1'b1; hold = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_rdata = '0;
        test_reset();
        test_single_load();
        test_store_fetch();
        test_simultaneous();
        test_starvation();
        test_hold();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
